// File: rtl/vx_tcu_drl_result_fixup_if.sv
// Handshake bundle between the FEDP result path, the exception-flag path and TCU writeback.
// Flag vectors are packed as {sign, is_nan, is_inf}.
interface vx_tcu_drl_result_fixup_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) ();
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             exc_valid;
  logic             exc_ready;
  logic [2:0]       exc_data;
  logic [TAG_W-1:0] exc_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_special;
  logic             out_nv;
  logic             err_tag;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, exc_valid, exc_data, exc_tag, res_valid, res_data, res_tag, out_ready,
    input  exc_ready, res_ready, out_valid, out_data, out_tag, out_special, out_nv,
           err_tag, occupancy
  );

  modport slave (
    input  flush, exc_valid, exc_data, exc_tag, res_valid, res_data, res_tag, out_ready,
    output exc_ready, res_ready, out_valid, out_data, out_tag, out_special, out_nv,
           err_tag, occupancy
  );
endinterface

// File: rtl/vx_tcu_drl_result_fixup.sv
// Aligns per-dot-product exception flags with returning FEDP results and substitutes
// IEEE special values before handing the result to writeback through an output register.
module vx_tcu_drl_result_fixup #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  vx_tcu_drl_result_fixup_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  logic [2:0]       flagMem_q [DEPTH];
  logic [TAG_W-1:0] tagMem_q  [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outData_q, outData_d;
  logic [TAG_W-1:0] outTag_q, outTag_d;
  logic             outSpecial_q, outSpecial_d;
  logic             outNv_q, outNv_d;
  logic             errTag_q, errTag_d;

  logic             excReady, resReady, pushFire, popFire;
  logic [2:0]       headFlags;
  logic [TAG_W-1:0] headTag;
  logic [31:0]      mergedData;
  logic             mergedSpecial, mergedNv;

  // Both readies depend only on registered state and out_ready, never on the valids.
  assign excReady = (occ_q != OCC_W'(DEPTH));
  assign resReady = (occ_q != '0) & (~outValid_q | bus.out_ready);
  assign pushFire = bus.exc_valid & excReady & ~bus.flush;
  assign popFire  = bus.res_valid & resReady & ~bus.flush;

  assign headFlags = flagMem_q[rdPtr_q];
  assign headTag   = tagMem_q[rdPtr_q];

  always_comb begin
    mergedData    = bus.res_data;
    mergedSpecial = 1'b0;
    mergedNv      = 1'b0;
    if (headFlags[1]) begin
      mergedData    = QNAN;
      mergedSpecial = 1'b1;
      mergedNv      = 1'b1;
    end else if (headFlags[0]) begin
      mergedData    = headFlags[2] ? NEG_INF : POS_INF;
      mergedSpecial = 1'b1;
    end
  end

  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    occ_d        = occ_q;
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    outTag_d     = outTag_q;
    outSpecial_d = outSpecial_q;
    outNv_d      = outNv_q;
    errTag_d     = errTag_q;
    if (bus.flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      occ_d      = '0;
      outValid_d = 1'b0;
      errTag_d   = 1'b0;
    end else begin
      if (pushFire) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popFire) begin
        rdPtr_d      = rdPtr_q + PTR_W'(1);
        outValid_d   = 1'b1;
        outData_d    = mergedData;
        outTag_d     = bus.res_tag;
        outSpecial_d = mergedSpecial;
        outNv_d      = mergedNv;
        if (bus.res_tag != headTag) begin
          errTag_d = 1'b1;
        end
      end else if (bus.out_ready) begin
        outValid_d = 1'b0;
      end
      if (pushFire && !popFire) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (popFire && !pushFire) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      occ_q        <= '0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outTag_q     <= '0;
      outSpecial_q <= 1'b0;
      outNv_q      <= 1'b0;
      errTag_q     <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      occ_q        <= occ_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outTag_q     <= outTag_d;
      outSpecial_q <= outSpecial_d;
      outNv_q      <= outNv_d;
      errTag_q     <= errTag_d;
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (pushFire) begin
      flagMem_q[wrPtr_q] <= bus.exc_data;
      tagMem_q[wrPtr_q]  <= bus.exc_tag;
    end
  end

  assign bus.exc_ready   = excReady;
  assign bus.res_ready   = resReady;
  assign bus.out_valid   = outValid_q;
  assign bus.out_data    = outData_q;
  assign bus.out_tag     = outTag_q;
  assign bus.out_special = outSpecial_q;
  assign bus.out_nv      = outNv_q;
  assign bus.err_tag     = errTag_q;
  assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_vx_tcu_drl_result_fixup.sv
// Directed bench for the exception/result fixup stage; expected outputs are queued
// when a result is accepted and popped by an independent monitor.
module tb_vx_tcu_drl_result_fixup;
  logic clk;
  logic reset_n;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
    logic        special;
    logic        nv;
  } expT;

  expT sbQueue[$];
  int  errorCount = 0;
  int  checkCount = 0;

  vx_tcu_drl_result_fixup_if #(.DEPTH(4), .TAG_W(8)) bus ();

  vx_tcu_drl_result_fixup #(.DEPTH(4), .TAG_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    errorCount++;
    $display("[TB] FAIL %s: handshake timed out", name);
  endtask

  task automatic applyStimulusExc(input logic [2:0] flags, input logic [7:0] tag);
    int budget = 0;
    bus.exc_valid = 1'b1;
    bus.exc_data  = flags;
    bus.exc_tag   = tag;
    while (!bus.exc_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.exc_ready) timeoutFail("excHandshake");
    @(posedge clk); #1;
    bus.exc_valid = 1'b0;
  endtask

  task automatic applyStimulusRes(input logic [31:0] data, input logic [7:0] tag,
                                  input logic [31:0] expData, input logic expSpecial,
                                  input logic expNv);
    int budget = 0;
    bus.res_valid = 1'b1;
    bus.res_data  = data;
    bus.res_tag   = tag;
    while (!bus.res_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!bus.res_ready) timeoutFail("resHandshake");
    else sbQueue.push_back('{data: expData, tag: tag, special: expSpecial, nv: expNv});
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
  endtask

  // Monitor: compares every output beat the consumer accepts against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sbQueue.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpectedOutput: got data %h tag %h with empty scoreboard",
                 bus.out_data, bus.out_tag);
      end else begin
        expT e;
        e = sbQueue.pop_front();
        checkOutput("outData", bus.out_data, e.data);
        checkOutput("outTag", 32'(bus.out_tag), 32'(e.tag));
        checkOutput("outSpecial", 32'(bus.out_special), 32'(e.special));
        checkOutput("outNv", 32'(bus.out_nv), 32'(e.nv));
      end
    end
  end

  initial begin
    logic [2:0]  drainFlags [4];
    logic [31:0] drainExp   [4];
    int          budget;

    reset_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_data  = '0;
    bus.exc_tag   = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_tag   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstExcReady", 32'(bus.exc_ready), 32'd1);
    checkOutput("rstResReady", 32'(bus.res_ready), 32'd0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOutSpecial", 32'(bus.out_special), 32'd0);
    checkOutput("rstOutNv", 32'(bus.out_nv), 32'd0);
    checkOutput("rstErrTag", 32'(bus.err_tag), 32'd0);
    checkOutput("rstOccupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("rstOutData", bus.out_data, 32'd0);
    checkOutput("rstOutTag", 32'(bus.out_tag), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Normal pass-through, flags one cycle ahead of the result.
    applyStimulusExc(3'b000, 8'd5);
    applyStimulusRes(32'h4049_0FDB, 8'd5, 32'h4049_0FDB, 1'b0, 1'b0);
    checkOutput("latencyOutValid", 32'(bus.out_valid), 32'd1);

    // Special-value overrides, including NaN taking priority over Inf.
    applyStimulusExc(3'b101, 8'd1);
    applyStimulusExc(3'b010, 8'd2);
    applyStimulusExc(3'b001, 8'd6);
    applyStimulusExc(3'b111, 8'd7);
    applyStimulusRes(32'h3F80_0000, 8'd1, 32'hFF80_0000, 1'b1, 1'b0);
    applyStimulusRes(32'h0000_0000, 8'd2, 32'h7FC0_0000, 1'b1, 1'b1);
    applyStimulusRes(32'h1234_5678, 8'd6, 32'h7F80_0000, 1'b1, 1'b0);
    applyStimulusRes(32'hC000_0000, 8'd7, 32'h7FC0_0000, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Result offered to an empty FIFO must be blocked.
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hDEAD_BEEF;
    bus.res_tag   = 8'h99;
    #1;
    checkOutput("emptyResReady", 32'(bus.res_ready), 32'd0);
    checkOutput("emptyOccupancy", 32'(bus.occupancy), 32'd0);
    @(posedge clk); #1;
    bus.res_valid = 1'b0;

    // Fill to capacity, hold a fifth push, then drain.
    drainFlags = '{3'b000, 3'b100, 3'b001, 3'b000};
    drainExp   = '{32'h1111_0000, 32'h2222_0000, 32'h7F80_0000, 32'h4444_0000};
    for (int i = 0; i < 4; i++) applyStimulusExc(drainFlags[i], 8'h10 + 8'(i));
    checkOutput("fullExcReady", 32'(bus.exc_ready), 32'd0);
    checkOutput("fullOccupancy", 32'(bus.occupancy), 32'd4);
    bus.exc_valid = 1'b1;
    bus.exc_data  = 3'b010;
    bus.exc_tag   = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("heldPushOccupancy", 32'(bus.occupancy), 32'd4);
    bus.exc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulusRes(32'(i + 1) * 32'h1111_0000, 8'h10 + 8'(i), drainExp[i],
                       (i == 2) ? 1'b1 : 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulusExc(3'b000, 8'h30 + 8'(i));
      applyStimulusRes(32'h1000_0000 + 32'(i), 8'h30 + 8'(i), 32'h1000_0000 + 32'(i),
                       1'b0, 1'b0);
    end
    @(posedge clk); #1;
    checkOutput("wrapErrTag", 32'(bus.err_tag), 32'd0);
    checkOutput("wrapOccupancy", 32'(bus.occupancy), 32'd0);

    // Push and pop in the same cycle leave occupancy unchanged.
    applyStimulusExc(3'b000, 8'h40);
    bus.exc_valid = 1'b1;
    bus.exc_data  = 3'b001;
    bus.exc_tag   = 8'h41;
    bus.res_valid = 1'b1;
    bus.res_data  = 32'h5555_AAAA;
    bus.res_tag   = 8'h40;
    #1;
    checkOutput("simulResReady", 32'(bus.res_ready), 32'd1);
    sbQueue.push_back('{data: 32'h5555_AAAA, tag: 8'h40, special: 1'b0, nv: 1'b0});
    @(posedge clk); #1;
    bus.exc_valid = 1'b0;
    bus.res_valid = 1'b0;
    checkOutput("simulOccupancy", 32'(bus.occupancy), 32'd1);
    applyStimulusRes(32'h0BAD_F00D, 8'h41, 32'h7F80_0000, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Backpressure: a held output blocks further results and stays stable.
    bus.out_ready = 1'b0;
    applyStimulusExc(3'b000, 8'h50);
    applyStimulusExc(3'b000, 8'h51);
    applyStimulusRes(32'hAAAA_0001, 8'h50, 32'hAAAA_0001, 1'b0, 1'b0);
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hAAAA_0002;
    bus.res_tag   = 8'h51;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bpResReady", 32'(bus.res_ready), 32'd0);
      checkOutput("bpOutValid", 32'(bus.out_valid), 32'd1);
      checkOutput("bpOutDataHeld", bus.out_data, 32'hAAAA_0001);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bpReleaseResReady", 32'(bus.res_ready), 32'd1);
    sbQueue.push_back('{data: 32'hAAAA_0002, tag: 8'h51, special: 1'b0, nv: 1'b0});
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Tag mismatch: sticky error, merge still follows the head flags.
    applyStimulusExc(3'b010, 8'd3);
    applyStimulusRes(32'h3F80_0000, 8'd4, 32'h7FC0_0000, 1'b1, 1'b1);
    checkOutput("tagErrSet", 32'(bus.err_tag), 32'd1);
    applyStimulusExc(3'b000, 8'd8);
    applyStimulusRes(32'h4000_0000, 8'd8, 32'h4000_0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("tagErrSticky", 32'(bus.err_tag), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checkOutput("flushErrTag", 32'(bus.err_tag), 32'd0);
    checkOutput("flushOccupancy", 32'(bus.occupancy), 32'd0);

    // Asynchronous reset in the middle of a cycle with work outstanding.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulusExc(3'b000, 8'h60 + 8'(i));
    applyStimulusRes(32'h6000_0000, 8'h60, 32'h6000_0000, 1'b0, 1'b0);
    checkOutput("preRstOccupancy", 32'(bus.occupancy), 32'd3);
    checkOutput("preRstOutValid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("asyncRstOccupancy", 32'(bus.occupancy), 32'd0);
    sbQueue.delete();
    @(posedge clk); #3;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("postRstExcReady", 32'(bus.exc_ready), 32'd1);
    checkOutput("postRstResReady", 32'(bus.res_ready), 32'd0);
    @(posedge clk); #1;

    applyStimulusExc(3'b101, 8'h77);
    applyStimulusRes(32'h3F00_0000, 8'h77, 32'hFF80_0000, 1'b1, 1'b0);

    budget = 0;
    while (sbQueue.size() != 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (sbQueue.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drainScoreboard: %0d outputs never appeared, required 0",
               sbQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
